apb_bridge_ctrl: RTL

Control core of the AHB-to-APB bridge. Accepts one AHB transfer at a time and stalls the master with `Hreadyout` while the transfer is sequenced onto APB. Each transfer runs through the APB SETUP and ACCESS phases, with the slave select decoded from `Haddr`. Read data returns on `Hrdata`. The core sits between the AHB slave port and the four APB peripherals driven by `Pselx[3:0]`.

---
 rtl/apb_bridge_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: control core of an AHB-to-APB bridge.
// Takes one AHB transfer at a time and stalls the master through Hreadyout
// while the transfer runs the APB SETUP/ACCESS sequence.
// Optional feature macro: APB_PREADY_EN adds the Pready input so that slaves
// can stretch ACCESS. When it is undefined, ACCESS always lasts one cycle.
module apb_bridge_ctrl #(
    parameter int         NSLV = 4,
    parameter logic [3:0] BASE = 4'h8
) (
    input  logic            clock,
    input  logic            Hresetn,
    input  logic [1:0]      Htrans,
    input  logic            Hwrite,
    input  logic            Hreadyin,
    input  logic [31:0]     Haddr,
    input  logic [31:0]     Hwdata,
    input  logic [2:0]      Hsize,
    input  logic [2:0]      Hburst,
    input  logic [31:0]     Prdata,
`ifdef APB_PREADY_EN
    input  logic            Pready,
`endif
    output logic            Hreadyout,
    output logic [1:0]      Hresp,
    output logic [31:0]     Hrdata,
    output logic [NSLV-1:0] Pselx,
    output logic            Penable,
    output logic            Pwrite,
    output logic [31:0]     Paddr,
    output logic [31:0]     Pwdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WWAIT  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_valid;
    logic              w_load;
    logic              w_done;
    logic [1:0]        w_idx;
    logic [NSLV-1:0]   w_dec;
    logic              r_hreadyout;
    logic [31:0]       r_hrdata;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;
    logic              w_unused;

    // Burst and size are irrelevant: every beat is sequenced on its own.
    assign w_unused = ^{Hsize, Hburst};

    // A transfer is taken only in IDLE. In every other state Hreadyout is low,
    // so a compliant master cannot present a new address phase there.
    assign w_valid = Hreadyin && Htrans[1] && (Haddr[31:28] == BASE);
    assign w_load  = (r_state == ST_IDLE) && w_valid;

`ifdef APB_PREADY_EN
    assign w_done = Pready;
`else
    assign w_done = 1'b1;
`endif

    // At the accepting edge the address is still on Haddr and not yet in
    // Paddr, so the slave select is decoded from whichever holds it.
    assign w_idx = w_load ? Haddr[27:26] : r_paddr[27:26];

    // Convert the slave index into a one-hot select.
    always_comb begin
        w_dec        = '0;
        w_dec[w_idx] = 1'b1;
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next = Hwrite ? ST_WWAIT : ST_SETUP;
            ST_WWAIT:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_done) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Registered outputs. They are decoded from the next state so that they
    // line up with the state register in the same cycle.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            r_hreadyout <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hrdata    <= '0;
        end else begin
            r_hreadyout <= (w_next == ST_IDLE);
            r_penable   <= (w_next == ST_ACCESS);
            r_psel      <= (w_next == ST_SETUP || w_next == ST_ACCESS) ? w_dec : '0;
            if (w_load) begin
                r_paddr  <= Haddr;
                r_pwrite <= Hwrite;
            end
            if (r_state == ST_WWAIT)
                r_pwdata <= Hwdata;
            if (r_state == ST_ACCESS && w_done && !r_pwrite)
                r_hrdata <= Prdata;
        end
    end

    assign Hreadyout = r_hreadyout;
    assign Hresp     = 2'b00;
    assign Hrdata    = r_hrdata;
    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule
